// File: rtl/jpeg_ff_stuff_packer.sv
// JPEG back-end bit packer: pops Huffman codes from the FF-check FIFO and packs them MSB-first
// into 32-bit words, stuffing 0x00 after 0xFF. JPEG_FF_EOI_APPEND_EN appends an EOI marker.
module jpeg_ff_stuff_packer #(
  parameter int unsigned ENTRY_W = 91,
  parameter int unsigned ACC_W   = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_fifo_empty,
  output logic               o_read_req,
  input  logic [ENTRY_W-1:0] i_read_data,
  input  logic               i_rdata_valid,
  output logic [31:0]        o_out_data,
  output logic [2:0]         o_out_bytes,
  output logic               o_out_last,
  output logic               o_out_valid,
  input  logic               i_out_ready
);

  localparam int unsigned CntW = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {StRun, StFlush, StEoi, StTail} state_e;

  state_e           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CntW-1:0]  r_acc_cnt, w_cnt_nxt;
  logic             r_inflight, r_last_seen, r_stuff_pending, r_presented;
  logic [31:0]      r_word, w_word_nxt;
  logic [2:0]       r_wcnt, w_wcnt_nxt;

  logic [5:0]       w_bc;
  logic [31:0]      w_code;
  logic             w_unused_bits;
  logic             w_fire, w_tail, w_more, w_hold, w_tail_done;
  logic             w_can_push, w_push_stuff, w_push_eoi, w_push_data, w_push;
  logic             w_eoi_left;
  logic [7:0]       w_eoi_byte, w_byte;
  logic [CntW-1:0]  w_pad_cnt, w_cnt_ext;
  logic [ACC_W-1:0] w_acc_pad, w_acc_ext, w_app;
  logic [2:0]       w_base;

  assign w_unused_bits = ^i_read_data[83:32];
  assign w_bc   = (i_read_data[89:84] > 6'd32) ? 6'd32 : i_read_data[89:84];
  assign w_code = i_read_data[31:0] & ~(32'hFFFF_FFFF >> w_bc);

  assign w_tail = (r_state == StTail);
  assign w_more = (r_acc_cnt != '0) || r_stuff_pending || w_eoi_left;
  // A full word that might be the last of the scan waits until we know whether anything follows.
  assign w_hold = r_last_seen && !w_more && !r_presented;

  assign o_out_valid = (r_wcnt != 3'd0) && (w_tail || ((r_wcnt == 3'd4) && !w_hold));
  assign o_out_last  = o_out_valid && w_tail;
  assign o_out_data  = r_word;
  assign o_out_bytes = r_wcnt;
  assign w_fire      = o_out_valid && i_out_ready;

  assign o_read_req = !i_fifo_empty && !r_inflight && (r_acc_cnt <= CntW'(32)) &&
                      (r_state == StRun) && !r_last_seen;

`ifdef JPEG_FF_EOI_APPEND_EN
  logic [1:0] r_eoi_idx;
  assign w_eoi_left = (r_eoi_idx != 2'd2);
  assign w_push_eoi = w_can_push && !r_stuff_pending && (r_state == StEoi) && w_eoi_left;
  assign w_eoi_byte = (r_eoi_idx == 2'd0) ? 8'hFF : 8'hD9;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_eoi_idx <= 2'd0;
    end else if (w_tail_done) begin
      r_eoi_idx <= 2'd0;
    end else if (w_push_eoi) begin
      r_eoi_idx <= r_eoi_idx + 2'd1;
    end
  end
`else
  assign w_eoi_left = 1'b0;
  assign w_push_eoi = 1'b0;
  assign w_eoi_byte = 8'hFF;
`endif

  // Flush pads the partial byte with 1s; outside flush the mask below collapses to zero.
  assign w_pad_cnt = (r_state == StFlush) ? ((r_acc_cnt + CntW'(7)) & ~CntW'(7)) : r_acc_cnt;
  assign w_acc_pad = r_acc | (({ACC_W{1'b1}} >> r_acc_cnt) & ~({ACC_W{1'b1}} >> w_pad_cnt));

  assign w_can_push   = !w_tail && ((r_wcnt != 3'd4) || w_fire);
  assign w_push_stuff = w_can_push && r_stuff_pending;
  assign w_push_data  = w_can_push && !r_stuff_pending && !w_push_eoi &&
                        (w_pad_cnt >= CntW'(8));
  assign w_push       = w_push_stuff || w_push_eoi || w_push_data;
  assign w_byte       = w_push_stuff ? 8'h00 :
                        w_push_eoi   ? w_eoi_byte : w_acc_pad[ACC_W-1 -: 8];

  assign w_acc_ext = w_push_data ? (w_acc_pad << 8) : w_acc_pad;
  assign w_cnt_ext = w_push_data ? (w_pad_cnt - CntW'(8)) : w_pad_cnt;
  assign w_app     = {w_code, {(ACC_W-32){1'b0}}} >> w_cnt_ext;
  assign w_acc_nxt = i_rdata_valid ? (w_acc_ext | w_app) : w_acc_ext;
  assign w_cnt_nxt = w_cnt_ext + (i_rdata_valid ? CntW'(w_bc) : '0);

  assign w_base = w_fire ? 3'd0 : r_wcnt;

  always_comb begin
    w_word_nxt = w_fire ? 32'h0 : r_word;
    if (w_push) begin
      case (w_base)
        3'd0:    w_word_nxt[31:24] = w_byte;
        3'd1:    w_word_nxt[23:16] = w_byte;
        3'd2:    w_word_nxt[15:8]  = w_byte;
        default: w_word_nxt[7:0]   = w_byte;
      endcase
    end
    w_wcnt_nxt = w_base + {2'b00, w_push};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tail_done = 1'b0;
    case (r_state)
      StRun:   if (r_last_seen && !r_inflight) w_state_nxt = StFlush;
      StFlush: begin
        if ((r_acc_cnt == '0) && !r_stuff_pending) begin
`ifdef JPEG_FF_EOI_APPEND_EN
          w_state_nxt = StEoi;
`else
          w_state_nxt = StTail;
`endif
        end
      end
      StEoi:   if (!w_eoi_left) w_state_nxt = StTail;
      StTail: begin
        if ((r_wcnt == 3'd0) || w_fire) begin
          w_state_nxt = StRun;
          w_tail_done = 1'b1;
        end
      end
      default: w_state_nxt = StRun;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= StRun;
      r_acc           <= '0;
      r_acc_cnt       <= '0;
      r_inflight      <= 1'b0;
      r_last_seen     <= 1'b0;
      r_stuff_pending <= 1'b0;
      r_presented     <= 1'b0;
      r_word          <= '0;
      r_wcnt          <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_acc_cnt   <= w_cnt_nxt;
      r_word      <= w_word_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_presented <= o_out_valid && !i_out_ready;
      if (o_read_req)         r_inflight <= 1'b1;
      else if (i_rdata_valid) r_inflight <= 1'b0;
      if (w_tail_done)                                r_last_seen <= 1'b0;
      else if (i_rdata_valid && i_read_data[90])      r_last_seen <= 1'b1;
      if (w_push_stuff)                               r_stuff_pending <= 1'b0;
      else if (w_push_data && (w_byte == 8'hFF))      r_stuff_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jpeg_ff_stuff_packer.sv
// Scoreboard bench for jpeg_ff_stuff_packer: directed scans plus randomized scans checked
// against a bit-queue reference model; honours JPEG_FF_EOI_APPEND_EN.
module tb_jpeg_ff_stuff_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic        read_req;
  logic [90:0] read_data;
  logic        rdata_valid;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  logic [90:0] fifo_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          rand_ready = 0;
  bit          rand_empty = 0;
  bit          hold_low = 0;

  jpeg_ff_stuff_packer #(.ENTRY_W(91), .ACC_W(64)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fifo_empty (fifo_empty),
    .o_read_req   (read_req),
    .i_read_data  (read_data),
    .i_rdata_valid(rdata_valid),
    .o_out_data   (out_data),
    .o_out_bytes  (out_bytes),
    .o_out_last   (out_last),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Entry builder; ignored bits and code bits below bit_count are filled with noise.
  function automatic logic [90:0] mk(input int cnt, input logic [31:0] code, input bit last);
    logic [90:0] e;
    logic [63:0] g;
    logic [31:0] noise;
    g = {$urandom(), $urandom()};
    noise = $urandom();
    e = '0;
    e[90] = last;
    e[89:84] = cnt[5:0];
    e[83:32] = g[51:0];
    e[31:0] = (cnt >= 32) ? code : (code | (noise & (32'hFFFF_FFFF >> cnt)));
    return e;
  endfunction

  task automatic push_exp(input logic [31:0] d, input int nb, input bit last);
    word_t w;
    w.data = d;
    w.bytes = 3'(nb);
    w.last = last;
    exp_q.push_back(w);
  endtask

  // Reference: flat bit list -> pad -> bytes with stuffing -> optional EOI -> 4-byte words.
  task automatic model_scan(input logic [90:0] ents[$]);
    bit          bits[$];
    logic [7:0]  bq[$];
    logic [7:0]  b;
    int          n;
    int          nb;
    logic [31:0] d;
    foreach (ents[k]) begin
      n = int'(ents[k][89:84]);
      if (n > 32) n = 32;
      for (int i = 0; i < n; i++) bits.push_back(ents[k][31-i]);
    end
    while (bits.size() % 8 != 0) bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i += 8) begin
      for (int j = 0; j < 8; j++) b[7-j] = bits[i+j];
      bq.push_back(b);
      if (b == 8'hFF) bq.push_back(8'h00);
    end
`ifdef JPEG_FF_EOI_APPEND_EN
    bq.push_back(8'hFF);
    bq.push_back(8'hD9);
`endif
    for (int i = 0; i < bq.size(); i += 4) begin
      nb = (bq.size() - i < 4) ? (bq.size() - i) : 4;
      d = '0;
      for (int j = 0; j < nb; j++) d[31-8*j -: 8] = bq[i+j];
      push_exp(d, nb, (i + 4 >= bq.size()));
    end
  endtask

  task automatic feed(input logic [90:0] ents[$]);
    foreach (ents[k]) fifo_q.push_back(ents[k]);
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && c < 3000) begin
      @(posedge clk);
      c++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (12) @(posedge clk);
  endtask

  // FIFO model: one-cycle read latency, optional random empty bubbles.
  initial begin : fifo_proc
    bit issued;
    fifo_empty = 1'b1;
    rdata_valid = 1'b0;
    read_data = '0;
    forever begin
      @(posedge clk);
      issued = read_req && !rst;
      #1;
      if (issued && fifo_q.size() > 0) begin
        read_data = fifo_q.pop_front();
        rdata_valid = 1'b1;
      end else begin
        rdata_valid = 1'b0;
      end
      fifo_empty = (fifo_q.size() == 0) || (rand_empty && $urandom_range(0, 3) == 0);
    end
  end

  initial begin : ready_proc
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_low) out_ready = 1'b0;
      else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
    end
  end

  initial begin : monitor_proc
    bit          prev_stall = 0;
    logic [35:0] prev_word = '0;
    word_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_word", 64'({out_data, out_bytes, out_last}), 64'(prev_word));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got 0x%0h/%0d last=%0d, expected no word",
                     out_data, out_bytes, out_last);
          end else begin
            e = exp_q.pop_front();
            chk("word", 64'({out_data, out_bytes, out_last}), 64'(e));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_word = {out_data, out_bytes, out_last};
      end
    end
  end

  initial begin : main_proc
    logic [90:0] ents[$];
    logic [31:0] code;
    int          ne;
    int          c;
    rst = 1'b1;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_bytes", 64'(out_bytes), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_read_req", 64'(read_req), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 1: two 16-bit codes
    ents = '{mk(16, 32'h1234_0000, 0), mk(16, 32'h5678_0000, 1)};
`ifdef JPEG_FF_EOI_APPEND_EN
    push_exp(32'h1234_5678, 4, 0);
    push_exp(32'hFFD9_0000, 2, 1);
`else
    push_exp(32'h1234_5678, 4, 1);
`endif
    feed(ents);
    wait_drain("t1_drain");

    // 2: 0xFF stuffing
    ents = '{mk(16, 32'hFFAB_0000, 1)};
`ifdef JPEG_FF_EOI_APPEND_EN
    push_exp(32'hFF00_ABFF, 4, 0);
    push_exp(32'hD900_0000, 1, 1);
`else
    push_exp(32'hFF00_AB00, 3, 1);
`endif
    feed(ents);
    wait_drain("t2_drain");

    // 3: 1-padding of partial byte
    ents = '{mk(5, 32'hA800_0000, 1)};
`ifdef JPEG_FF_EOI_APPEND_EN
    push_exp(32'hAFFF_D900, 3, 1);
`else
    push_exp(32'hAF00_0000, 1, 1);
`endif
    feed(ents);
    wait_drain("t3_drain");

    // 4: dummy slots interleaved
    ents = '{mk(0, 32'h0, 0), mk(16, 32'h1234_0000, 0), mk(0, 32'h0, 0), mk(0, 32'h0, 0),
             mk(16, 32'h5678_0000, 1)};
`ifdef JPEG_FF_EOI_APPEND_EN
    push_exp(32'h1234_5678, 4, 0);
    push_exp(32'hFFD9_0000, 2, 1);
`else
    push_exp(32'h1234_5678, 4, 1);
`endif
    feed(ents);
    wait_drain("t4_drain");

    // 5: backpressure with eight full entries
    hold_low = 1;
    repeat (2) @(posedge clk);
    ents = {};
    for (int i = 0; i < 8; i++) ents.push_back(mk(32, 32'h0F0F_0F0F, i == 7));
    model_scan(ents);
    feed(ents);
    c = 0;
    while (!out_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("t5_valid_seen", 64'(out_valid), 64'd1);
    repeat (10) @(negedge clk);
    chk("t5_read_req_stalled", 64'(read_req), 64'd0);
    hold_low = 0;
    wait_drain("t5_drain");

    // 6: async reset mid-stream
    hold_low = 1;
    repeat (2) @(posedge clk);
    ents = '{mk(32, 32'hA1B2_C3D4, 0), mk(20, 32'h9ABC_D000, 0)};
    feed(ents);
    repeat (20) @(negedge clk);
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_data", 64'(out_data), 64'd0);
    chk("t6_rst_bytes", 64'(out_bytes), 64'd0);
    chk("t6_rst_last", 64'(out_last), 64'd0);
    fifo_q.delete();
    exp_q.delete();
    hold_low = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    ents = '{mk(16, 32'h1234_0000, 0), mk(16, 32'h5678_0000, 1)};
`ifdef JPEG_FF_EOI_APPEND_EN
    push_exp(32'h1234_5678, 4, 0);
    push_exp(32'hFFD9_0000, 2, 1);
`else
    push_exp(32'h1234_5678, 4, 1);
`endif
    feed(ents);
    wait_drain("t6_drain");

    // Randomized scans: random ready, FIFO bubbles, FF-heavy codes, oversize bit counts.
    rand_ready = 1;
    rand_empty = 1;
    for (int s = 0; s < 25; s++) begin
      ents = {};
      ne = $urandom_range(1, 6);
      for (int i = 0; i < ne; i++) begin
        for (int j = 0; j < 4; j++)
          code[8*j +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom());
        if (i == ne - 1) ents.push_back(mk($urandom_range(1, 32), code, 1));
        else ents.push_back(mk($urandom_range(0, 40), code, 0));
      end
      model_scan(ents);
      feed(ents);
      wait_drain("rand_drain");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
